wb_stream_fifo: RTL and testbench
=================================

# wb_stream_fifo

Parametrised, buffered successor to the baseband pass-through interface. It sits between two Wishbone-style streaming baseband stages. Each sample is DAT Im[31:16] / Re[15:0] in 5.11 format. It decouples upstream and downstream with a DEPTH-entry FIFO and regenerates frame (CYC) boundaries on the output. It removes the combinational ACK_I→ACK_O path of the pass-through version.

## Interface
- DW, 32: data width (both ports)
- DEPTH, 4: FIFO entries; power of two, ≥2
- CLK_I  in  1  clock, all logic on rising edge
- RST_I  in  1  reset; synchronous, active-high
- DAT_I  in  DW  input sample
- WE_I  in  1  input write qualifier
- STB_I  in  1  input strobe
- CYC_I  in  1  input frame/cycle valid
- ACK_O  out  1  input accepted this cycle
- DAT_O  out  DW  output sample
- WE_O  out  1  output write qualifier
- STB_O  out  1  output strobe
- CYC_O  out  1  output frame/cycle valid
- ACK_I  in  1  downstream accepted this cycle
- FILL_O  out  $clog2(DEPTH+1)  occupancy; present only with WB_FIFO_FILL_EN

## Operation
- Accept: ACK_O = CYC_I & STB_I & WE_I & ~full & ~RST_I.
  - ACK_O depends on registered full only, never on ACK_I.
  - A full FIFO does not accept, even when a pop happens in the same cycle.
- Each FIFO entry stores {first, DAT_I}.
  - first = 1 for the first accepted word after CYC_I rises.
  - Tracked by a cyc_seen flag: set on accept while CYC_I = 1, cleared in any cycle with CYC_I = 0.
- Pop: STB_O & ACK_I.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Full/empty come from a count register of width $clog2(DEPTH+1).
- DAT_O is the head entry when STB_O = 1, otherwise 0.
- WE_O = STB_O.
- Output FSM:
  - IDLE: CYC_O = 0, STB_O = 0. Go to ACTIVE when not empty. Clear sent.
  - ACTIVE: CYC_O = 1, STB_O = ~empty & ~(head.first & sent).
    - Set sent on pop.
    - If head.first & sent, go to GAP.
    - Else if empty & ~CYC_I, go to IDLE.
    - Empty with CYC_I = 1 is a mid-frame gap: stay in ACTIVE, CYC_O = 1, STB_O = 0.
  - GAP: CYC_O = 0, STB_O = 0 for exactly one cycle, then ACTIVE with sent cleared.
- Reset (including mid-frame):
  - count and pointers are 0, FSM goes to IDLE, sent and cyc_seen are 0.
  - All buffered data is discarded.
  - Memory contents are not reset.
- Reset values: ACK_O 0, STB_O 0, CYC_O 0, WE_O 0, DAT_O 0, FILL_O 0.

## Timing
- Latency: a word accepted in cycle n can appear on STB_O/DAT_O in cycle n+1 at the earliest.
  - From IDLE, cycle n+1 is the FSM transition cycle. CYC_O and STB_O both rise in cycle n+1.
- Throughput: 1 word/cycle sustained when ACK_I = 1 continuously and 0 < count < DEPTH.
- Backpressure: with ACK_I = 0, at most DEPTH words are accepted. ACK_O drops in the cycle after count reaches DEPTH.
- Frame separation: at least one CYC_O-low cycle between the last word of frame k and the first word of frame k+1. This holds even when both frames are buffered together.
- Memory read is combinational from the registered array; all outputs except ACK_O come from registers or the array.

## Configuration
- WB_FIFO_FILL_EN defined: FILL_O port exists and equals the count register, which is updated in the same edge as push/pop.
- WB_FIFO_FILL_EN undefined: FILL_O port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package bb_wb_pkg:
  - sample-format constants (SAMPLE_W = 32, RE_LSB = 0, IM_LSB = 16, FRAC = 11)
  - typedef of the FIFO entry {first, data}
  - the FSM state enum (IDLE, ACTIVE, GAP)
- One sub-module, wb_fifo_mem: DEPTH×(DW+1) storage with write port and combinational read.
- Pointers, count, accept logic and the FSM stay in the top module.

## Test plan
- Single frame: CYC_I/STB_I/WE_I high for 3 words 0x0001_0800, 0x0002_1000, 0x0003_1800 with ACK_I = 1.
  - ACK_O high for 3 cycles.
  - Same 3 words on DAT_O, each exactly one cycle later.
  - CYC_O falls once the FIFO is empty and CYC_I is low.
- Backpressure, DEPTH = 4: ACK_I = 0 while 6 words are offered.
  - Exactly 4 ACK_O pulses.
  - FILL_O = 4.
  - After ACK_I = 1, all 4 words come out in order and ACK_O resumes.
- Back-to-back frames: frame A (2 words), CYC_I low 1 cycle, frame B (2 words), with ACK_I = 0 until all 4 are buffered.
  - Output: A0, A1, one CYC_O-low GAP cycle, then B0, B1.
- Mid-frame input gap: STB_I low 3 cycles while CYC_I stays high.
  - CYC_O stays high with STB_O low; no GAP is inserted.
- Simultaneous push/pop at count = 2: count remains 2 and DAT_O order is preserved.
  - At count = DEPTH with ACK_I = 1, ACK_O = 0 for that cycle.
- Reset mid-frame: RST_I for 1 cycle with 3 words buffered.
  - The next cycle has all outputs 0 and FILL_O = 0.
  - A new frame then passes with its first word flagged first.

Source files
------------

// File: rtl/bb_wb_pkg.sv
// bb_wb_pkg: shared baseband Wishbone-stream definitions (sample format, FIFO entry, output FSM states)
package bb_wb_pkg;
   localparam int SAMPLE_W = 32;
   localparam int RE_LSB   = 0;
   localparam int IM_LSB   = 16;
   localparam int FRAC     = 11;
   typedef struct packed {
      logic                first;
      logic [SAMPLE_W-1:0] data;
   } fifo_entry_t;
   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} out_state_t;
endpackage

// File: rtl/wb_fifo_mem.sv
// wb_fifo_mem: DEPTH x W storage, synchronous write, combinational read
//   clk            clock
//   we/waddr/wdata write port
//   raddr/rdata    combinational read port
module wb_fifo_mem import bb_wb_pkg::*; #(
   parameter int W     = SAMPLE_W + 1,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/wb_stream_fifo.sv
// wb_stream_fifo: buffered Wishbone-style sample stream with frame (CYC) regeneration
//   CLK_I, RST_I                      clock, synchronous active-high reset
//   DAT_I, WE_I, STB_I, CYC_I, ACK_O  upstream (slave) side
//   DAT_O, WE_O, STB_O, CYC_O, ACK_I  downstream (master) side
//   FILL_O                            occupancy, only when WB_FIFO_FILL_EN is defined
module wb_stream_fifo import bb_wb_pkg::*; #(
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                       CLK_I,
   input  logic                       RST_I,
   input  logic [DW-1:0]              DAT_I,
   input  logic                       WE_I,
   input  logic                       STB_I,
   input  logic                       CYC_I,
   output logic                       ACK_O,
   output logic [DW-1:0]              DAT_O,
   output logic                       WE_O,
   output logic                       STB_O,
   output logic                       CYC_O,
   input  logic                       ACK_I
`ifdef WB_FIFO_FILL_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] FILL_O
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_n;
   logic [DW:0]   head;
   logic          cyc_seen, sent, push, pop, full, empty, hold;
   out_state_t    state;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign ACK_O   = CYC_I & STB_I & WE_I & ~full & ~RST_I;
   assign push    = ACK_O;
   // head starts a new frame after words of the current one were sent: hold it back for a gap
   assign hold    = ~empty & head[DW] & sent;
   assign STB_O   = (state == ACTIVE) & ~empty & ~hold;
   assign CYC_O   = state == ACTIVE;
   assign WE_O    = STB_O;
   assign DAT_O   = STB_O ? head[DW-1:0] : '0;
   assign pop     = STB_O & ACK_I;
   assign count_n = count + CW'(push) - CW'(pop);
`ifdef WB_FIFO_FILL_EN
   assign FILL_O  = count;
`endif
   wb_fifo_mem #(.W(DW+1), .DEPTH(DEPTH)) u_mem (
      .clk(CLK_I), .we(push), .waddr(wr_ptr), .wdata({~cyc_seen, DAT_I}),
      .raddr(rd_ptr), .rdata(head)
   );
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         cyc_seen <= 1'b0;
         sent     <= 1'b0;
         state    <= IDLE;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count    <= count_n;
         cyc_seen <= CYC_I & (cyc_seen | push);
         case (state)
            IDLE: begin
               sent <= 1'b0;
               // using the next count lets a word accepted now show up on the very next cycle
               if (count_n != '0) state <= ACTIVE;
            end
            ACTIVE: begin
               if (pop) sent <= 1'b1;
               if (hold) state <= GAP;
               else if (empty & ~CYC_I) state <= IDLE;
            end
            GAP: begin
               sent  <= 1'b0;
               state <= ACTIVE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_stream_fifo.sv
// tb_wb_stream_fifo: directed and random stimulus against a queue-based reference model
module tb_wb_stream_fifo;
   import bb_wb_pkg::*;
   localparam int DEPTH = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b1, we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0, ack_i = 1'b0;
   logic [31:0] dat_i = '0;
   logic        ack_o, we_o, stb_o, cyc_o;
   logic [31:0] dat_o;
`ifdef WB_FIFO_FILL_EN
   logic [2:0]  fill_o;
`endif
   always #5 clk = ~clk;
   wb_stream_fifo #(.DW(32), .DEPTH(DEPTH)) dut (
      .CLK_I(clk), .RST_I(rst), .DAT_I(dat_i), .WE_I(we_i), .STB_I(stb_i), .CYC_I(cyc_i),
      .ACK_O(ack_o), .DAT_O(dat_o), .WE_O(we_o), .STB_O(stb_o), .CYC_O(cyc_o), .ACK_I(ack_i)
`ifdef WB_FIFO_FILL_EN
      , .FILL_O(fill_o)
`endif
   );
   int checks = 0, errors = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   fifo_entry_t q[$];
   fifo_entry_t e;
   bit mon_en = 0, in_frame = 0, exp_ack;
   int burst = 0, stall = 0, ack_cnt = 0;
   always @(negedge clk) if (mon_en) begin
      exp_ack = cyc_i & stb_i & we_i & (q.size() < DEPTH) & ~rst;
      check("ack_o", ack_o, exp_ack);
      check("we_o", we_o, stb_o);
`ifdef WB_FIFO_FILL_EN
      check("fill_o", fill_o, q.size());
`endif
      if (ack_o) ack_cnt++;
      if (!cyc_o) burst = 0;
      if (stb_o) begin
         check("stb_nonempty", q.size() != 0, 1);
         if (q.size() != 0) begin
            e = q[0];
            check("dat_o", dat_o, e.data);
            check("frame_sep", burst == 0, e.first);
            if (ack_i) begin
               void'(q.pop_front());
               burst++;
            end
         end
      end else check("dat_idle", dat_o, 0);
      stall = (!rst && q.size() != 0 && ack_i && !stb_o) ? stall + 1 : 0;
      if (stall > 3) begin
         check("stall", stall, 3);
         stall = 0;
      end
      if (rst) begin
         q.delete();
         in_frame = 0;
      end else begin
         if (exp_ack) q.push_back('{first: !in_frame, data: dat_i});
         in_frame = cyc_i & (in_frame | exp_ack);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_in(input bit c, input bit s, input bit w, input bit a, input logic [31:0] d);
      cyc_i = c; stb_i = s; we_i = w; ack_i = a; dat_i = d;
   endtask
   task automatic drain();
      set_in(0, 0, 0, 1, 0);
      repeat (10) tick();
   endtask
   logic [31:0] sf_w[3] = '{32'h0001_0800, 32'h0002_1000, 32'h0003_1800};
   logic [31:0] bb_w[4] = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00B0, 32'h0000_00B1};
   int a0, npop, lows;
   bit c;
   initial begin
      tick();
      mon_en = 1;
      @(negedge clk);
      check("rst_stb", stb_o, 0);
      check("rst_cyc", cyc_o, 0);
      check("rst_dat", dat_o, 0);
      check("rst_ack", ack_o, 0);
      tick();
      rst = 0;
      tick();
      // single frame, each word visible exactly one cycle after acceptance
      a0 = ack_cnt;
      for (int i = 0; i < 4; i++) begin
         set_in(i < 3, i < 3, i < 3, 1, i < 3 ? sf_w[i] : 32'h0);
         @(negedge clk);
         if (i > 0) begin
            check("sf_stb", stb_o, 1);
            check("sf_dat", dat_o, sf_w[i-1]);
         end
         tick();
      end
      check("sf_acks", ack_cnt - a0, 3);
      tick();
      tick();
      @(negedge clk);
      check("sf_cyc_fall", cyc_o, 0);
      drain();
      // backpressure: only DEPTH of 6 offers accepted, then drain in order
      a0 = ack_cnt;
      for (int i = 0; i < 6; i++) begin
         set_in(1, 1, 1, 0, $urandom);
         tick();
      end
      check("bp_acks", ack_cnt - a0, DEPTH);
`ifdef WB_FIFO_FILL_EN
      @(negedge clk);
      check("bp_fill", fill_o, DEPTH);
`endif
      for (int i = 0; i < 4; i++) begin
         set_in(1, 1, 1, 1, $urandom);
         tick();
      end
      check("bp_resume", ack_cnt - a0 > DEPTH, 1);
      drain();
      // back-to-back frames buffered together must be split by one CYC_O-low cycle
      set_in(1, 1, 1, 0, bb_w[0]); tick();
      set_in(1, 1, 1, 0, bb_w[1]); tick();
      set_in(0, 0, 0, 0, 0);       tick();
      set_in(1, 1, 1, 0, bb_w[2]); tick();
      set_in(1, 1, 1, 0, bb_w[3]); tick();
      set_in(0, 0, 0, 1, 0);
      npop = 0;
      lows = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (npop == 2 && !cyc_o) lows++;
         if (stb_o && npop < 4) begin
            check("b2b_dat", dat_o, bb_w[npop]);
            npop++;
         end
         tick();
      end
      check("b2b_pops", npop, 4);
      check("b2b_gap", lows, 1);
      drain();
      // mid-frame input gap keeps CYC_O high without a GAP
      set_in(1, 1, 1, 1, 32'h11); tick();
      set_in(1, 1, 1, 1, 32'h12); tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 0, 1, 0);
         @(negedge clk);
         check("mid_cyc", cyc_o, 1);
         if (i > 0) check("mid_stb", stb_o, 0);
         tick();
      end
      set_in(1, 1, 1, 1, 32'h13); tick();
      set_in(1, 1, 1, 1, 32'h14); tick();
      drain();
      // simultaneous push/pop at count 2, then full boundary with ACK_I high
      set_in(1, 1, 1, 0, 32'h21); tick();
      set_in(1, 1, 1, 0, 32'h22); tick();
      for (int i = 0; i < 4; i++) begin
         set_in(1, 1, 1, 1, 32'h30 + i);
         @(negedge clk);
         check("pp_ack", ack_o, 1);
         check("pp_stb", stb_o, 1);
`ifdef WB_FIFO_FILL_EN
         check("pp_fill", fill_o, 2);
`endif
         tick();
      end
      for (int i = 0; i < 10 && q.size() < DEPTH; i++) begin
         set_in(1, 1, 1, 0, 32'h40 + i);
         tick();
      end
      check("full_reached", q.size(), DEPTH);
      set_in(1, 1, 1, 1, 32'h50);
      @(negedge clk);
      check("full_ack", ack_o, 0);
      tick();
      @(negedge clk);
      check("after_full_ack", ack_o, 1);
      tick();
      drain();
      // reset mid-frame with 3 words buffered
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 1, 0, 32'h60 + i);
         tick();
      end
      set_in(0, 0, 0, 0, 0);
      rst = 1;
      tick();
      rst = 0;
      @(negedge clk);
      check("rst2_ack", ack_o, 0);
      check("rst2_stb", stb_o, 0);
      check("rst2_cyc", cyc_o, 0);
      check("rst2_we", we_o, 0);
      check("rst2_dat", dat_o, 0);
`ifdef WB_FIFO_FILL_EN
      check("rst2_fill", fill_o, 0);
`endif
      tick();
      set_in(1, 1, 1, 1, 32'h70); tick();
      @(negedge clk);
      check("rst2_new", dat_o, 32'h70);
      set_in(1, 1, 1, 1, 32'h71); tick();
      drain();
      // random traffic
      c = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) c = !c;
         rst = $urandom_range(499) == 0;
         set_in(c, $urandom_range(3) != 0, $urandom_range(7) != 0, $urandom_range(2) != 0, $urandom);
         tick();
      end
      rst = 0;
      drain();
      @(negedge clk);
      check("end_cyc", cyc_o, 0);
      check("end_stb", stb_o, 0);
      check("end_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
